// File: rtl/word_gen_dispatch_if.sv
// Bus bundle between the word generator, the dispatcher and the consumer units.
// The master view belongs to the dispatcher; the slave view to generator/unit models.
`timescale 1ns/1ps
interface word_gen_dispatch_if #(
  parameter int CHAR_BITS    = 7,
  parameter int WORD_MAX_LEN = 8,
  parameter int N_UNITS      = 4
);
  localparam int WORD_W = WORD_MAX_LEN * CHAR_BITS;

  logic                gen_empty;
  logic                gen_rd_en;
  logic [WORD_W-1:0]   gen_dout;
  logic [15:0]         gen_pkt_id;
  logic [15:0]         gen_word_id;
  logic [31:0]         gen_gen_id;
  logic                gen_end;

  logic [N_UNITS-1:0]  unit_full;
  logic [N_UNITS-1:0]  unit_wr_en;
  logic [N_UNITS-1:0]  unit_end_wr;
  logic [WORD_W-1:0]   unit_dout;
  logic [15:0]         unit_pkt_id;
  logic [15:0]         unit_word_id;
  logic [31:0]         unit_gen_id;

  modport master (
    input  gen_empty, gen_dout, gen_pkt_id, gen_word_id, gen_gen_id, gen_end, unit_full,
    output gen_rd_en, unit_wr_en, unit_end_wr, unit_dout, unit_pkt_id, unit_word_id, unit_gen_id
  );

  modport slave (
    output gen_empty, gen_dout, gen_pkt_id, gen_word_id, gen_gen_id, gen_end, unit_full,
    input  gen_rd_en, unit_wr_en, unit_end_wr, unit_dout, unit_pkt_id, unit_word_id, unit_gen_id
  );
endinterface

// File: rtl/word_gen_dispatch.sv
// Pulls words from a generator through a single holding register and deals them
// round-robin to non-full units, then broadcasts end-of-packet markers to every unit.
`timescale 1ns/1ps
module word_gen_dispatch #(
  parameter int CHAR_BITS    = 7,
  parameter int WORD_MAX_LEN = 8,
  parameter int N_UNITS      = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 enable,
  word_gen_dispatch_if.master  bus,
  output logic [31:0]          words_sent,
  output logic                 idle
);
  localparam int WORD_W = WORD_MAX_LEN * CHAR_BITS;
  localparam int PTR_W  = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
  localparam logic [PTR_W-1:0] LAST_UNIT = PTR_W'(N_UNITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nx_s;
  logic                hold_valid_r;
  logic                hold_last_r;
  logic [PTR_W-1:0]    rr_ptr_r;
  logic [PTR_W-1:0]    flush_idx_r;
  logic [31:0]         words_sent_r;
  logic [WORD_W-1:0]   dout_r;
  logic [15:0]         pkt_id_r;
  logic [15:0]         word_id_r;
  logic [31:0]         gen_id_r;

  logic [PTR_W-1:0]    scan_s;
  logic [PTR_W-1:0]    target_s;
  logic                found_s;
  logic                accept_s;
  logic                pop_s;
  logic                flush_fire_s;
  logic                flush_done_s;
  logic [N_UNITS-1:0]  wr_en_s;
  logic [N_UNITS-1:0]  end_wr_s;

  // First non-full unit at or above rr_ptr, wrapping around the unit ring.
  always_comb begin
    found_s  = 1'b0;
    target_s = {PTR_W{1'b0}};
    scan_s   = rr_ptr_r;
    for (int k = 0; k < N_UNITS; k++) begin
      scan_s = PTR_W'((int'(rr_ptr_r) + k) % N_UNITS);
      if (!found_s && !bus.unit_full[scan_s]) begin
        found_s  = 1'b1;
        target_s = scan_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Next-state decode plus the combinational pop and strobe outputs.
  always_comb begin
    state_nx_s   = state_r;
    accept_s     = 1'b0;
    pop_s        = 1'b0;
    flush_fire_s = 1'b0;
    flush_done_s = 1'b0;
    wr_en_s      = {N_UNITS{1'b0}};
    end_wr_s     = {N_UNITS{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (enable && !bus.gen_empty) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        accept_s = hold_valid_r && found_s;
        // A word leaving the holding register frees it for a same-cycle refill.
        pop_s    = enable && !bus.gen_empty && !hold_last_r && (!hold_valid_r || accept_s);
        if (accept_s) begin
          wr_en_s[target_s] = 1'b1;
        end else begin
          wr_en_s = {N_UNITS{1'b0}};
        end
        if (accept_s && hold_last_r) begin
          state_nx_s = ST_FLUSH;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        flush_fire_s = !bus.unit_full[flush_idx_r];
        flush_done_s = flush_fire_s && (flush_idx_r == LAST_UNIT);
        if (flush_fire_s) begin
          end_wr_s[flush_idx_r] = 1'b1;
        end else begin
          end_wr_s = {N_UNITS{1'b0}};
        end
        if (flush_done_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_FLUSH;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Holding register; its data stays on the unit bus after acceptance so the
  // packet id remains visible while markers go out.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_valid_r <= 1'b0;
      hold_last_r  <= 1'b0;
      dout_r       <= {WORD_W{1'b0}};
      pkt_id_r     <= 16'h0000;
      word_id_r    <= 16'h0000;
      gen_id_r     <= 32'h0000_0000;
    end else if (pop_s) begin
      hold_valid_r <= 1'b1;
      hold_last_r  <= bus.gen_end;
      dout_r       <= bus.gen_dout;
      pkt_id_r     <= bus.gen_pkt_id;
      word_id_r    <= bus.gen_word_id;
      gen_id_r     <= bus.gen_gen_id;
    end else if (accept_s) begin
      hold_valid_r <= 1'b0;
      hold_last_r  <= 1'b0;
    end else begin
      hold_valid_r <= hold_valid_r;
      hold_last_r  <= hold_last_r;
    end
  end

  // Round-robin pointer, marker index and saturating per-packet word count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_ptr_r     <= {PTR_W{1'b0}};
      flush_idx_r  <= {PTR_W{1'b0}};
      words_sent_r <= 32'h0000_0000;
    end else if (accept_s) begin
      rr_ptr_r     <= (target_s == LAST_UNIT) ? {PTR_W{1'b0}} : target_s + {{(PTR_W-1){1'b0}}, 1'b1};
      words_sent_r <= (words_sent_r == 32'hFFFF_FFFF) ? words_sent_r : words_sent_r + 32'd1;
    end else if (flush_done_s) begin
      rr_ptr_r     <= {PTR_W{1'b0}};
      flush_idx_r  <= {PTR_W{1'b0}};
      words_sent_r <= 32'h0000_0000;
    end else if (flush_fire_s) begin
      flush_idx_r  <= flush_idx_r + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      rr_ptr_r     <= rr_ptr_r;
    end
  end

  assign bus.gen_rd_en    = pop_s;
  assign bus.unit_wr_en   = wr_en_s;
  assign bus.unit_end_wr  = end_wr_s;
  assign bus.unit_dout    = dout_r;
  assign bus.unit_pkt_id  = pkt_id_r;
  assign bus.unit_word_id = word_id_r;
  assign bus.unit_gen_id  = gen_id_r;
  assign words_sent       = words_sent_r;
  assign idle             = (state_r == ST_IDLE) && !hold_valid_r;

endmodule

// File: tb/tb_word_gen_dispatch.sv
// Scoreboard bench for word_gen_dispatch: directed packets push expected unit
// strobes into a queue that an independent negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_word_gen_dispatch;
  localparam int CB = 7;
  localparam int WL = 8;
  localparam int NU = 4;
  localparam int WW = CB * WL;

  typedef struct {
    int          unit;
    bit          is_end;
    logic [15:0] pkt;
    logic [15:0] wid;
    logic [31:0] ws;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        enable;
  logic [31:0] words_sent;
  logic        idle;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   wr_first = -1;
  int   wr_last = 0;
  int   end_cyc[NU];

  logic [15:0] g_pkt = 16'h0000;
  logic [15:0] g_base = 16'h0000;
  int          g_n = 0;
  int          rd_idx = 0;
  bit          pend;

  word_gen_dispatch_if #(.CHAR_BITS(CB), .WORD_MAX_LEN(WL), .N_UNITS(NU)) bus ();

  word_gen_dispatch #(.CHAR_BITS(CB), .WORD_MAX_LEN(WL), .N_UNITS(NU)) dut (
    .CLK(CLK), .RST_N(RST_N), .enable(enable), .bus(bus),
    .words_sent(words_sent), .idle(idle)
  );

  always #5 CLK = ~CLK;

  function automatic logic [WW-1:0] word_data(input logic [15:0] wid);
    logic [WW-1:0] d;
    d = '0;
    for (int c = 0; c < WL; c++) d[c*CB +: CB] = CB'(int'(wid) * 3 + c + 1);
    return d;
  endfunction

  function automatic logic [31:0] gid_of(input logic [15:0] wid);
    return {16'hC0DE, wid ^ 16'h5A5A};
  endfunction

  // Generator model: presents word rd_idx of the loaded packet.
  assign bus.gen_empty   = (rd_idx >= g_n);
  assign bus.gen_word_id = g_base + 16'(rd_idx);
  assign bus.gen_dout    = word_data(g_base + 16'(rd_idx));
  assign bus.gen_gen_id  = gid_of(g_base + 16'(rd_idx));
  assign bus.gen_pkt_id  = g_pkt;
  assign bus.gen_end     = (rd_idx == g_n - 1);

  initial begin
    forever begin
      @(negedge CLK);
      pend = bus.gen_rd_en;
      @(posedge CLK);
      #1;
      if (pend) rd_idx++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic load_pkt(input logic [15:0] pkt, input logic [15:0] base, input int n);
    g_pkt = pkt; g_base = base; g_n = n; rd_idx = 0;
  endtask

  task automatic push_word(input int unit, input logic [15:0] pkt, input logic [15:0] wid, input int ws);
    exp_t e;
    e.unit = unit; e.is_end = 1'b0; e.pkt = pkt; e.wid = wid; e.ws = 32'(ws);
    exp_q.push_back(e);
  endtask

  task automatic push_ends(input logic [15:0] pkt, input int ws);
    exp_t e;
    for (int u = 0; u < NU; u++) begin
      e.unit = u; e.is_end = 1'b1; e.pkt = pkt; e.wid = 16'h0000; e.ws = 32'(ws);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string name, input int max);
    int t;
    t = 0;
    do begin
      @(negedge CLK);
      t++;
    end while (!(idle === 1'b1 && exp_q.size() == 0) && t < max);
    chk(name, 64'(idle === 1'b1 && exp_q.size() == 0), 64'd1);
  endtask

  // Monitor: every strobe cycle pops one expectation and checks bus contents.
  initial begin
    exp_t e;
    logic [NU-1:0] vec;
    forever begin
      @(negedge CLK);
      cyc++;
      if (bus.unit_wr_en != '0 || bus.unit_end_wr != '0) begin
        chk("strobe_onehot_exclusive",
            64'($onehot(bus.unit_wr_en | bus.unit_end_wr) && !(|bus.unit_wr_en && |bus.unit_end_wr)), 64'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {56'd0, bus.unit_wr_en, bus.unit_end_wr}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          vec = '0;
          vec[e.unit] = 1'b1;
          if (e.is_end) begin
            chk("end_wr_unit", 64'(bus.unit_end_wr), 64'(vec));
            chk("end_pkt_id", 64'(bus.unit_pkt_id), 64'(e.pkt));
            chk("end_words_sent", 64'(words_sent), 64'(e.ws));
            end_cyc[e.unit] = cyc;
          end else begin
            chk("wr_unit", 64'(bus.unit_wr_en), 64'(vec));
            chk("wr_dout", 64'(bus.unit_dout), 64'(word_data(e.wid)));
            chk("wr_pkt_id", 64'(bus.unit_pkt_id), 64'(e.pkt));
            chk("wr_word_id", 64'(bus.unit_word_id), 64'(e.wid));
            chk("wr_gen_id", 64'(bus.unit_gen_id), 64'(gid_of(e.wid)));
            chk("wr_words_sent", 64'(words_sent), 64'(e.ws));
            if (wr_first < 0) wr_first = cyc;
            wr_last = cyc;
          end
        end
      end
    end
  end

  initial begin
    int t;
    int units2[6] = '{0, 2, 3, 0, 2, 3};
    RST_N = 1'b0;
    enable = 1'b0;
    bus.unit_full = 4'b0000;
    repeat (2) @(negedge CLK);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_rd_en", 64'(bus.gen_rd_en), 64'd0);
    chk("rst_wr_en", 64'(bus.unit_wr_en), 64'd0);
    chk("rst_end_wr", 64'(bus.unit_end_wr), 64'd0);
    chk("rst_words_sent", 64'(words_sent), 64'd0);
    chk("rst_dout", 64'(bus.unit_dout), 64'd0);
    @(posedge CLK); #1 RST_N = 1'b1;

    // Eight words, no back-pressure: strict rotation at one word per cycle.
    for (int k = 0; k < 8; k++) push_word(k % NU, 16'h0A01, 16'(k), k);
    push_ends(16'h0A01, 8);
    wr_first = -1;
    @(posedge CLK); #1;
    load_pkt(16'h0A01, 16'h0000, 8);
    enable = 1'b1;
    wait_done("basic_done", 100);
    chk("basic_throughput", 64'(wr_last - wr_first), 64'd7);
    chk("basic_marker_run", 64'(end_cyc[3] - end_cyc[0]), 64'd3);
    chk("basic_ws_cleared", 64'(words_sent), 64'd0);

    // Unit 1 full throughout the words, then holds up its end marker 3 cycles.
    for (int k = 0; k < 6; k++) push_word(units2[k], 16'h0B02, 16'h0010 + 16'(k), k);
    push_ends(16'h0B02, 6);
    @(posedge CLK); #1;
    bus.unit_full = 4'b0010;
    load_pkt(16'h0B02, 16'h0010, 6);
    t = 0;
    do begin @(negedge CLK); t++; end while (bus.unit_end_wr !== 4'b0001 && t < 200);
    chk("skip_marker0_seen", 64'(t < 200), 64'd1);
    repeat (4) @(posedge CLK);
    #1 bus.unit_full = 4'b0000;
    wait_done("skip_done", 100);
    chk("flush_stall_len", 64'(end_cyc[1] - end_cyc[0]), 64'd4);
    chk("flush_tail_len", 64'(end_cyc[3] - end_cyc[1]), 64'd2);

    // All units full with a word held, then unit 2 frees.
    push_word(2, 16'h0C03, 16'h0020, 0);
    push_word(3, 16'h0C03, 16'h0021, 1);
    push_word(0, 16'h0C03, 16'h0022, 2);
    push_ends(16'h0C03, 3);
    @(posedge CLK); #1;
    bus.unit_full = 4'b1111;
    load_pkt(16'h0C03, 16'h0020, 3);
    t = 0;
    do begin @(negedge CLK); t++; end while (bus.unit_word_id !== 16'h0020 && t < 50);
    chk("full_word_held", 64'(bus.unit_dout), 64'(word_data(16'h0020)));
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("full_no_pop", 64'(bus.gen_rd_en), 64'd0);
      chk("full_no_strobe", 64'(bus.unit_wr_en), 64'd0);
      chk("full_bus_stable", 64'(bus.unit_dout), 64'(word_data(16'h0020)));
    end
    @(posedge CLK); #1 bus.unit_full = 4'b1011;
    @(negedge CLK);
    chk("release_unit2", 64'(bus.unit_wr_en), 64'h4);
    @(posedge CLK); #1 bus.unit_full = 4'b0000;
    wait_done("full_done", 100);

    // enable dropped right after the third pop.
    for (int k = 0; k < 6; k++) push_word(k % NU, 16'h0D04, 16'h0030 + 16'(k), k);
    push_ends(16'h0D04, 6);
    @(posedge CLK); #1;
    load_pkt(16'h0D04, 16'h0030, 6);
    t = 0;
    do begin @(negedge CLK); t++; end while (!(rd_idx == 2 && bus.gen_rd_en === 1'b1) && t < 50);
    chk("en_third_pop_seen", 64'(t < 50), 64'd1);
    @(posedge CLK); #1 enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("en_off_no_pop", 64'(bus.gen_rd_en), 64'd0);
      if (i > 0) chk("en_off_words_sent", 64'(words_sent), 64'd3);
    end
    chk("en_off_pop_count", 64'(rd_idx), 64'd3);
    @(posedge CLK); #1 enable = 1'b1;
    wait_done("en_done", 100);

    // Reset while a word is held; pointer must restart at unit 0.
    push_word(1, 16'h0E05, 16'h0040, 0);
    @(posedge CLK); #1;
    bus.unit_full = 4'b0001;
    load_pkt(16'h0E05, 16'h0040, 4);
    t = 0;
    do begin @(negedge CLK); t++; end while (bus.unit_wr_en === 4'b0000 && t < 50);
    @(posedge CLK); #1 bus.unit_full = 4'b1111;
    repeat (3) @(negedge CLK);
    chk("rst_mid_held_word", 64'(bus.unit_word_id), 64'h0041);
    @(posedge CLK); #1 RST_N = 1'b0;
    #1;
    chk("rst_mid_wr_en", 64'(bus.unit_wr_en), 64'd0);
    chk("rst_mid_rd_en", 64'(bus.gen_rd_en), 64'd0);
    chk("rst_mid_dout", 64'(bus.unit_dout), 64'd0);
    chk("rst_mid_word_id", 64'(bus.unit_word_id), 64'd0);
    chk("rst_mid_idle", 64'(idle), 64'd1);
    load_pkt(16'h0000, 16'h0000, 0);
    bus.unit_full = 4'b0000;
    @(posedge CLK); #1 RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("post_rst_quiet", 64'(bus.unit_wr_en), 64'd0);
      chk("post_rst_idle", 64'(idle), 64'd1);
    end
    push_word(0, 16'h0F06, 16'h0050, 0);
    push_word(1, 16'h0F06, 16'h0051, 1);
    push_ends(16'h0F06, 2);
    @(posedge CLK); #1;
    load_pkt(16'h0F06, 16'h0050, 2);
    wait_done("post_rst_done", 100);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
